// File: rtl/icache_line_fill_pkg.sv
// Shared types and geometry for the instruction cache line-fill block.
// Contents:
//   S_OFFSET / S_INDEX / S_TAG  - address split (32-byte lines, 8 sets)
//   icache_state_t              - controller states CHECK, FILL, REFILLED
//   line_t                      - one cache line (256 bits)
//   line_word()                 - selects one 32-bit word out of a line
package icache_line_fill_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int S_LINE   = 8 << S_OFFSET;
    localparam int SETS     = 1 << S_INDEX;
    localparam int S_WORD   = S_OFFSET - 2;

    typedef enum logic [1:0] {
        CHECK    = 2'd0,
        FILL     = 2'd1,
        REFILLED = 2'd2
    } icache_state_t;

    typedef logic [S_LINE-1:0] line_t;

    function automatic logic [31:0] line_word(input line_t line, input logic [S_WORD-1:0] word);
        return line[{word, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Instruction fetch bus between the pipeline fetch stage and the cache.
//   read  - fetch request (master -> slave)
//   addr  - byte address, bits [1:0] ignored (master -> slave)
//   resp  - rdata valid this cycle (slave -> master)
//   rdata - instruction word (slave -> master)
// master = fetch stage, slave = cache.
interface icache_line_fill_if;
    logic        read;
    logic [31:0] addr;
    logic        resp;
    logic [31:0] rdata;

    modport master (output read, output addr, input resp, input rdata);
    modport slave  (input read, input addr, output resp, output rdata);
endinterface

// File: rtl/icache_line_fill_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset (clears valid bits only)
//   flush                - clears every valid bit at the next edge; wins over a same-cycle write
//   rd_index             - set to look up; rd_valid/rd_tag/rd_data are combinational
//   wr_en/wr_index/...   - installs a line (tag + data, sets valid)
module icache_line_fill_array
    import icache_line_fill_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [S_INDEX-1:0] rd_index,
    output logic               rd_valid,
    output logic [S_TAG-1:0]   rd_tag,
    output line_t              rd_data,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_index,
    input  logic [S_TAG-1:0]   wr_tag,
    input  line_t              wr_data
);

    logic [SETS-1:0] valid_vec;
    logic [S_TAG-1:0] tag_vec [SETS];
    line_t            data_vec [SETS];

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic             valid_reg;
            logic [S_TAG-1:0] tag_reg;
            line_t            data_reg;
            logic             sel;

            assign sel = wr_en && (wr_index == S_INDEX'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else if (flush) begin
                    // A flush landing on the fill edge leaves the new line invalid.
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    valid_reg <= 1'b1;
                end
            end

            // Tag and data hold no meaning while invalid, so they are never reset.
            always_ff @(posedge clk) begin
                if (sel) begin
                    tag_reg  <= wr_tag;
                    data_reg <= wr_data;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign tag_vec[gi]   = tag_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign rd_valid = valid_vec[rd_index];
    assign rd_tag   = tag_vec[rd_index];
    assign rd_data  = data_vec[rd_index];

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Hits answer in the same cycle; a miss costs pmem latency + 2 cycles.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   fetch          - fetch bus (slave side): read/addr in, resp/rdata out
//   flush          - invalidate all lines
//   pmem_read      - line fill request, held until pmem_resp
//   pmem_address   - line-aligned fill address
//   pmem_rdata     - fill line, valid with pmem_resp
//   pmem_resp      - single-cycle fill data strobe
//   hit_count      - saturating count of hit responses
//   miss_count     - saturating count of misses entering FILL
module icache_line_fill
    import icache_line_fill_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    icache_line_fill_if.slave         fetch,
    input  logic                      flush,
    output logic                      pmem_read,
    output logic [31:0]               pmem_address,
    input  line_t                     pmem_rdata,
    input  logic                      pmem_resp,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);

    icache_state_t state_reg, state_next;

    // Line address of the miss being filled; latched so a dropped request
    // may move inst_addr without disturbing the fill in progress.
    logic [31-S_OFFSET:0] fill_line_reg;
    logic [31:0]          hit_count_reg;
    logic [31:0]          miss_count_reg;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [S_WORD-1:0]  req_word;
    logic               unused_addr_low;

    logic               rd_valid;
    logic [S_TAG-1:0]   rd_tag;
    line_t              rd_data;
    logic               hit;
    logic               miss;
    logic               install;

    assign req_tag         = fetch.addr[31:S_OFFSET+S_INDEX];
    assign req_index       = fetch.addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign req_word        = fetch.addr[S_OFFSET-1:2];
    assign unused_addr_low = ^fetch.addr[1:0];

    assign install = (state_reg == FILL) && pmem_resp;

    icache_line_fill_array u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (install),
        .wr_index (fill_line_reg[S_INDEX-1:0]),
        .wr_tag   (fill_line_reg[31-S_OFFSET:S_INDEX]),
        .wr_data  (pmem_rdata)
    );

    assign hit  = (state_reg == CHECK) && fetch.read && rd_valid && (rd_tag == req_tag);
    assign miss = (state_reg == CHECK) && fetch.read && !hit;

    assign fetch.resp   = hit;
    assign fetch.rdata  = line_word(rd_data, req_word);
    assign pmem_read    = (state_reg == FILL);
    assign pmem_address = {fill_line_reg, {S_OFFSET{1'b0}}};
    assign hit_count    = hit_count_reg;
    assign miss_count   = miss_count_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            CHECK:    if (miss) state_next = FILL;
            FILL:     if (pmem_resp) state_next = REFILLED;
            REFILLED: state_next = CHECK;
            default:  state_next = CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= CHECK;
            fill_line_reg  <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss) begin
                fill_line_reg <= fetch.addr[31:S_OFFSET];
            end
            if (hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed scenarios followed by
// randomized accesses, checked against a set-level model of the cache.
module tb_icache_line_fill;
    import icache_line_fill_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        pmem_read;
    logic [31:0] pmem_address;
    line_t       pmem_rdata;
    logic        pmem_resp;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_line_fill_if fetch_bus ();

    icache_line_fill dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch        (fetch_bus),
        .flush        (flush),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which line each set holds, plus event counts.
    bit          m_valid [8];
    logic [23:0] m_tag   [8];
    int unsigned m_hits;
    int unsigned m_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Backing memory contents: one word per aligned address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic line_t line_of(input logic [31:0] a);
        line_t       l;
        logic [31:0] base;
        base = a & 32'hFFFF_FFE0;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(base + 32'(4 * w));
        return l;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[7:5]] && (m_tag[a[7:5]] == a[31:8]);
    endfunction

    task automatic model_clear_valid();
        for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    endtask

    // One fetch of address a. On a miss the fill takes lat cycles of pmem
    // latency; fl_resp raises flush with the first pmem_resp; drop releases
    // inst_read (and scrambles the address) in the first FILL cycle.
    task automatic read_access(input logic [31:0] a, input int lat, input bit fl_resp, input bit drop);
        bit done;
        int attempt;
        bit fl;
        done    = 1'b0;
        attempt = 0;
        fl      = fl_resp;
        @(negedge clk);
        fetch_bus.read = 1'b1;
        fetch_bus.addr = a;
        while (!done) begin
            #1;
            if (fetch_bus.read && model_hit(a)) begin
                check("hit_resp", 32'(fetch_bus.resp), 32'd1);
                check("hit_rdata", fetch_bus.rdata, mem_word({a[31:2], 2'b00}));
                check("hit_no_pmem", 32'(pmem_read), 32'd0);
                m_hits++;
                done = 1'b1;
            end else begin
                check("miss_resp", 32'(fetch_bus.resp), 32'd0);
                if (!fetch_bus.read || attempt == 3) begin
                    done = 1'b1;
                end else begin
                    m_misses++;
                    attempt++;
                    for (int k = 1; k <= lat; k++) begin
                        @(negedge clk);
                        if (k == 1 && drop) begin
                            fetch_bus.read = 1'b0;
                            fetch_bus.addr = ~a;
                        end
                        if (k == lat) begin
                            pmem_resp  = 1'b1;
                            pmem_rdata = line_of(a);
                            flush      = fl;
                        end
                        #1;
                        check("fill_pmem_read", 32'(pmem_read), 32'd1);
                        check("fill_pmem_addr", pmem_address, {a[31:5], 5'b0});
                        check("fill_no_resp", 32'(fetch_bus.resp), 32'd0);
                    end
                    @(negedge clk);
                    pmem_resp  = 1'b0;
                    flush      = 1'b0;
                    pmem_rdata = {8{$urandom()}};
                    #1;
                    check("refilled_pmem_read", 32'(pmem_read), 32'd0);
                    check("refilled_no_resp", 32'(fetch_bus.resp), 32'd0);
                    if (fl) begin
                        model_clear_valid();
                    end else begin
                        m_valid[a[7:5]] = 1'b1;
                        m_tag[a[7:5]]   = a[31:8];
                    end
                    fl = 1'b0;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        fetch_bus.read = 1'b0;
        #1;
        check({tag, "_hits"}, hit_count, m_hits);
        check({tag, "_misses"}, miss_count, m_misses);
        check({tag, "_idle_pmem"}, 32'(pmem_read), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n          = 1'b0;
        flush          = 1'b0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        fetch_bus.read = 1'b1;
        fetch_bus.addr = 32'h40;
        model_clear_valid();
        for (int s = 0; s < 8; s++) m_tag[s] = '0;
        m_hits   = 0;
        m_misses = 0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_resp", 32'(fetch_bus.resp), 32'd0);
        check("reset_pmem_read", 32'(pmem_read), 32'd0);
        check("reset_hits", hit_count, 32'd0);
        check("reset_misses", miss_count, 32'd0);
        fetch_bus.read = 1'b0;
        rst_n          = 1'b1;

        // Cold miss with 3-cycle memory: response on cycle 5.
        read_access(32'h40, 3, 1'b0, 1'b0);
        check_counters("cold");

        // Hit stream over the rest of the line, back to back.
        for (int w = 1; w < 8; w++) read_access(32'h40 + 32'(4 * w), 1, 1'b0, 1'b0);
        check_counters("stream");
        check("stream_hit_total", hit_count, 32'd8);

        // Conflict on set 2: 0x140 evicts 0x40, which then misses again.
        read_access(32'h140, 2, 1'b0, 1'b0);
        read_access(32'h40, 2, 1'b0, 1'b0);
        check_counters("conflict");
        check("conflict_miss_total", miss_count, 32'd3);

        // Flush coinciding with pmem_resp: line lands invalid, re-check misses.
        read_access(32'h80, 2, 1'b1, 1'b0);
        check_counters("flush_fill");
        check("flush_fill_miss_total", miss_count, 32'd5);

        // Drop inst_read mid-fill, then re-request: the installed line hits.
        read_access(32'hA4, 3, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("dropped_no_resp", 32'(fetch_bus.resp), 32'd0);
        read_access(32'hA4, 3, 1'b0, 1'b0);
        check_counters("drop");

        // Flush during a hit still answers that cycle.
        @(negedge clk);
        fetch_bus.read = 1'b1;
        fetch_bus.addr = 32'hA8;
        flush          = 1'b1;
        #1;
        check("flush_hit_resp", 32'(fetch_bus.resp), 32'd1);
        check("flush_hit_rdata", fetch_bus.rdata, mem_word(32'hA8));
        m_hits++;
        model_clear_valid();
        @(negedge clk);
        flush          = 1'b0;
        fetch_bus.read = 1'b0;
        read_access(32'hA8, 1, 1'b0, 1'b0);
        check_counters("flush_hit");

        // Randomized accesses over 4 tags x 8 sets.
        for (int n = 0; n < 60; n++) begin
            a = {24'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            read_access(a, $urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 7) == 0));
        end
        check_counters("random");

        // Reset in the middle of a fill.
        @(negedge clk);
        a              = 32'h0007_77E0;
        fetch_bus.read = 1'b1;
        fetch_bus.addr = a;
        #1;
        check("rst_fill_miss", 32'(fetch_bus.resp), 32'd0);
        @(negedge clk);
        #1;
        check("rst_fill_pmem_read", 32'(pmem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear_valid();
        m_hits   = 0;
        m_misses = 0;
        check("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_async_hits", hit_count, 32'd0);
        check("rst_async_misses", miss_count, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        fetch_bus.read = 1'b0;
        pmem_resp      = 1'b1;
        pmem_rdata     = line_of(a);
        #1;
        check("late_resp_no_resp", 32'(fetch_bus.resp), 32'd0);
        check("late_resp_no_pmem", 32'(pmem_read), 32'd0);
        @(negedge clk);
        pmem_resp = 1'b0;
        read_access(a, 2, 1'b0, 1'b0);
        check_counters("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
